// File: rtl/bypass_ctrl.sv
// Bypass select and hazard stall/bubble control for the ID stage.
// Tracks destination/write-enable of the ID_EX, EX_DM and DM_WB instructions.
module bypass_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_addr_ID,
    input  logic              re0_ID,
    input  logic [ADDR_W-1:0] p1_addr_ID,
    input  logic              re1_ID,
    input  logic [ADDR_W-1:0] dst_addr_ID,
    input  logic              rf_we_ID,
    input  logic              dm_re_ID,
    input  logic              flow_change_EX,
    input  logic              ext_stall,
    output logic              byp0_EX,
    output logic              byp0_DM,
    output logic              byp1_EX,
    output logic              byp1_DM,
    output logic              stall_IF_ID,
    output logic              stall_ID_EX,
    output logic              stall_EX_DM,
    output logic              stall_DM_WB,
    output logic              bubble_ID_EX,
    output logic [CNT_W-1:0]  ld_use_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic              we;
        logic              ld;
    } id_ex_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic              we;
    } shdw_t;

    id_ex_t           id_ex_q;
    shdw_t            ex_dm_q;
    shdw_t            dm_wb_q;
    logic [3:0]       byp_q;
    logic [CNT_W-1:0] cnt_q;

    logic m_ex0, m_dm0, m_ex1, m_dm1;
    logic load_use;
    logic kill;

    always_comb begin
        m_ex0 = re0_ID && id_ex_q.we && (id_ex_q.dst == p0_addr_ID)
                && (p0_addr_ID != '0);
        m_dm0 = re0_ID && ex_dm_q.we && (ex_dm_q.dst == p0_addr_ID)
                && (p0_addr_ID != '0);
        m_ex1 = re1_ID && id_ex_q.we && (id_ex_q.dst == p1_addr_ID)
                && (p1_addr_ID != '0);
        m_dm1 = re1_ID && ex_dm_q.we && (ex_dm_q.dst == p1_addr_ID)
                && (p1_addr_ID != '0);
        load_use = id_ex_q.ld && (m_ex0 || m_ex1) && !flow_change_EX;
        kill     = flow_change_EX || load_use;
    end

    always_comb begin
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_DM  = 1'b0;
        stall_DM_WB  = 1'b0;
        bubble_ID_EX = 1'b0;
        if (ext_stall) begin
            stall_IF_ID = 1'b1;
            stall_ID_EX = 1'b1;
            stall_EX_DM = 1'b1;
            stall_DM_WB = 1'b1;
        end else if (flow_change_EX) begin
            bubble_ID_EX = 1'b1;
        end else if (load_use) begin
            stall_IF_ID  = 1'b1;
            bubble_ID_EX = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
            ex_dm_q <= '0;
            dm_wb_q <= '0;
            byp_q   <= '0;
            cnt_q   <= '0;
        end else if (!ext_stall) begin
            ex_dm_q <= '{dst: id_ex_q.dst, we: id_ex_q.we};
            dm_wb_q <= ex_dm_q;
            if (kill) begin
                id_ex_q <= '{dst: dst_addr_ID, we: 1'b0, ld: 1'b0};
                byp_q   <= '0;
            end else begin
                id_ex_q <= '{dst: dst_addr_ID, we: rf_we_ID, ld: dm_re_ID};
                byp_q   <= {m_ex0, m_dm0 && !m_ex0, m_ex1, m_dm1 && !m_ex1};
            end
            if (load_use && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign {byp0_EX, byp0_DM, byp1_EX, byp1_DM} = byp_q;
    assign ld_use_cnt = cnt_q;

endmodule

// File: doc/bypass_ctrl.md
Name: bypass_ctrl

Overview:
- Producer side of the RF bypass interface: generates the registered bypass selects byp0_EX/byp0_DM/byp1_EX/byp1_DM consumed in the EX stage.
- Generates pipeline stall/bubble controls for load-use hazards and branch flushes.
- Tracks destination register and write-enable of the instructions in ID_EX, EX_DM and DM_WB.
- Sits beside the ID-stage decoder; outputs feed the EX source muxes and pipeline-register enables.

Parameters:
- ADDR_W, 4, register-file address width (R0 hard-wired zero).
- CNT_W, 16, width of load-use stall performance counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- p0_addr_ID  input  ADDR_W  RF port-0 read address of instruction in ID
- re0_ID  input  1  instruction in ID reads port 0
- p1_addr_ID  input  ADDR_W  RF port-1 read address in ID
- re1_ID  input  1  instruction in ID reads port 1
- dst_addr_ID  input  ADDR_W  destination register of instruction in ID
- rf_we_ID  input  1  instruction in ID writes RF
- dm_re_ID  input  1  instruction in ID is a load (LW)
- flow_change_EX  input  1  taken branch/jump resolved in EX; kill ID instruction
- ext_stall  input  1  global freeze (e.g. memory busy)
- byp0_EX, byp0_DM, byp1_EX, byp1_DM  output  1 each  registered bypass selects, valid while instruction is in ID_EX
- stall_IF_ID  output  1  hold PC and IF_ID
- stall_ID_EX  output  1  hold ID_EX
- stall_EX_DM  output  1  hold EX_DM
- stall_DM_WB  output  1  hold DM_WB
- bubble_ID_EX  output  1  load NOP into ID_EX at next edge
- ld_use_cnt  output  CNT_W  saturating count of inserted load-use bubbles

Behaviour:

Shadow stages (flops):
- ID_EX: dst, we, ld.
- EX_DM: dst, we.
- DM_WB: dst, we.

Combinational matches in ID (shown for port 0; port 1 identical):
- mEX0 = re0_ID & we_IDEX & (dst_IDEX == p0_addr_ID) & (p0_addr_ID != 0).
- mDM0 = re0_ID & we_EXDM & (dst_EXDM == p0_addr_ID) & (p0_addr_ID != 0).
- Selects are mutually exclusive: next byp0_EX = mEX0; next byp0_DM = mDM0 & ~mEX0.
- DM_WB-vs-ID hazards are resolved by the write-before-read RF, not by this block.

Hazard detection:
- load_use = ld_IDEX & (mEX0 | mEX1) & ~flow_change_EX.

Priority, highest first:
- ext_stall = 1: all four stall outputs = 1, bubble = 0; every flop holds, including byp and counter. flow_change_EX is held by the frozen EX stage and acts after release.
- flow_change_EX = 1: bubble_ID_EX = 1; stall_IF_ID = 0 (fetch redirects). ID_EX shadow loads we=0, ld=0; byp regs load 0.
- load_use = 1: stall_IF_ID = 1, bubble_ID_EX = 1, other stalls = 0. ID_EX shadow loads we=0, ld=0; byp regs load 0; ld_use_cnt += 1, saturating at all-ones.
- Otherwise: no stall. ID_EX shadow loads (dst_addr_ID, rf_we_ID, dm_re_ID); byp regs load next values.

Advance rules:
- Whenever not ext_stall, EX_DM <- ID_EX and DM_WB <- EX_DM.
- Load-use latency: exactly one bubble. The following cycle the load sits in EX_DM, the consumer re-evaluates in ID and gets byp_DM.
- Stall outputs and bubble_ID_EX are combinational from current inputs and state. Byp outputs are flop outputs only.

Reset:
- All shadow we/ld = 0, dst = 0, byp regs = 0, ld_use_cnt = 0.
- With idle inputs after reset, all stalls and bubble = 0.
- Reset asserted mid-stall clears pending hazards immediately.

Test Plan:
1. ADD R3 then ADD R4,R3,R5 back-to-back (p0_addr_ID=3, we_IDEX=1, dst=3) -> next cycle byp0_EX=1, byp0_DM=0, no stall.
2. R3 written two instructions ahead with an unrelated instruction between -> byp0_DM=1 on consumer's EX cycle. Same R3 written by both older instructions -> byp0_EX=1, byp0_DM=0.
3. LW R2 followed by SUB R6,R7,R2 (p1 = 2) -> one cycle with stall_IF_ID=1, bubble_ID_EX=1, ld_use_cnt 0->1; then byp1_DM=1, byp1_EX=0.
4. Producer and consumer reference R0 (we=1, dst=0, p0=0) -> all byp outputs stay 0. Consumer with re0_ID=0 and matching address -> byp0_EX=0.
5. load_use and flow_change_EX in same cycle -> bubble=1, stall_IF_ID=0, counter unchanged. ext_stall=1 during a load-use -> all stalls=1, byp/counter hold, hazard resolves after ext_stall drops.
6. Force ld_use_cnt to 0xFFFF via repeated load-use hazards -> stays at 0xFFFF. Assert rst asynchronously mid-sequence -> byp, counter and stalls clear without a clock edge.
